dmem_ctrl: RTL and testbench

Two-port access controller that sequences the byte-addressed, big-endian data memory and shares it between the CPU load/store unit (port 0) and a loader/DMA engine (port 1). It arbitrates between the ports round-robin, drives the memory's chip-select, read/write and byte-select controls from registered outputs, and checks alignment. For loads it extracts and sign- or zero-extends byte and halfword data. It sits between the CPU core and the data memory instance; its clock also drives the memory clock.

---
 rtl/dmem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: shares the big-endian byte-addressed data memory between two
// requesters (port 0 = CPU load/store unit, port 1 = loader/DMA engine).
//
// Ports:
//   clk, rst               clock (also the memory clock), sync active-high reset
//   pN_req/we/size/sext    request handshake and access type (N = 0, 1)
//   pN_addr, pN_wdata      byte address, right-justified store data
//   pN_ack, pN_err         one-cycle completion pulse and its error flag
//   pN_rdata               extended load result, held until the next ack
//   dm_cs/r/w/addr/wdata/bits  registered memory controls
//   dm_rdata               memory read data, byte at addr in [31:24]
//   busy                   controller is not idle
//
// Every access takes three cycles: grant (IDLE), ACCESS, RESP (ack).
module dmem_ctrl #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_size,
    input  logic        p0_sext,
    input  logic [10:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_size,
    input  logic        p1_sext,
    input  logic [10:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic        dm_cs,
    output logic        dm_r,
    output logic        dm_w,
    output logic [10:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [1:0]  dm_bits,
    input  logic [31:0] dm_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [10:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t state, next_state;
    req_t   port_req [2];
    req_t   gnt_req;
    logic   grant, gnt_sel, gnt_bad;
    logic   prio;

    // Context of the access in flight.
    logic       cur_port, cur_we, cur_sext, cur_err;
    logic [1:0] cur_size;

    logic [1:0]       ack_q, err_q;
    logic [1:0][31:0] rdata_q;

    // Size 3 is illegal; halfwords and words must be naturally aligned.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = lo[0];
            2'd2:    misaligned = |lo;
            default: misaligned = 1'b1;
        endcase
    endfunction

    // The addressed byte always lands in dm_rdata[31:24], so the sign bit
    // for both byte and halfword loads is dm_rdata[31].
    function automatic logic [31:0] load_ext(input logic [31:0] rd,
                                             input logic [1:0]  size,
                                             input logic        sext);
        logic fill;
        fill = sext & rd[31];
        case (size)
            2'd0:    load_ext = {{24{fill}}, rd[31:24]};
            2'd1:    load_ext = {{16{fill}}, rd[31:16]};
            default: load_ext = rd;
        endcase
    endfunction

    assign port_req[0] = '{we: p0_we, size: p0_size, sext: p0_sext, addr: p0_addr, wdata: p0_wdata};
    assign port_req[1] = '{we: p1_we, size: p1_size, sext: p1_sext, addr: p1_addr, wdata: p1_wdata};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        gnt_sel    = prio;
        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    grant = 1'b1;
                    // A lone requester wins regardless of the pointer.
                    if (!(p0_req && p1_req)) gnt_sel = p1_req;
                    next_state = ACCESS;
                end
            end
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gnt_req = port_req[gnt_sel];
        gnt_bad = misaligned(gnt_req.size, gnt_req.addr[1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio     <= (PRIO_INIT != 0);
            cur_port <= 1'b0;
            cur_we   <= 1'b0;
            cur_sext <= 1'b0;
            cur_err  <= 1'b0;
            cur_size <= 2'd0;
            ack_q    <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            dm_cs    <= 1'b0;
            dm_r     <= 1'b0;
            dm_w     <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_bits  <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            if (grant) begin
                prio     <= ~gnt_sel;
                cur_port <= gnt_sel;
                cur_we   <= gnt_req.we;
                cur_sext <= gnt_req.sext;
                cur_size <= gnt_req.size;
                cur_err  <= gnt_bad;
                // A rejected access never touches the memory.
                if (!gnt_bad) begin
                    dm_cs    <= 1'b1;
                    dm_r     <= ~gnt_req.we;
                    dm_w     <= gnt_req.we;
                    dm_addr  <= gnt_req.addr;
                    dm_wdata <= gnt_req.wdata;
                    dm_bits  <= gnt_req.size;
                end
            end
            if (state == ACCESS) begin
                dm_cs    <= 1'b0;
                dm_r     <= 1'b0;
                dm_w     <= 1'b0;
                dm_addr  <= '0;
                dm_wdata <= '0;
                dm_bits  <= '0;
                ack_q[cur_port]   <= 1'b1;
                err_q[cur_port]   <= cur_err;
                rdata_q[cur_port] <= (cur_we || cur_err) ? 32'h0
                                                         : load_ext(dm_rdata, cur_size, cur_sext);
            end
        end
    end

    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p0_err   = err_q[0];
    assign p1_err   = err_q[1];
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: byte-array memory model driven by the dm_* pins,
// a byte-level reference model feeding per-port expected queues, and a
// forked monitor that pops and compares on every ack.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_i [2];
    logic        we_i [2];
    logic        sext_i [2];
    logic [1:0]  size_i [2];
    logic [10:0] addr_i [2];
    logic [31:0] wdata_i [2];

    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        dm_cs, dm_r, dm_w, busy;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic [1:0]  dm_bits;

    dmem_ctrl #(.PRIO_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .p0_req(req_i[0]), .p0_we(we_i[0]), .p0_size(size_i[0]), .p0_sext(sext_i[0]),
        .p0_addr(addr_i[0]), .p0_wdata(wdata_i[0]),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(req_i[1]), .p1_we(we_i[1]), .p1_size(size_i[1]), .p1_sext(sext_i[1]),
        .p1_addr(addr_i[1]), .p1_wdata(wdata_i[1]),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_bits(dm_bits), .dm_rdata(dm_rdata), .busy(busy)
    );

    // ---------------- memory device ----------------
    logic [7:0] mem [2048];
    logic       mem_init = 1'b0;

    always_comb begin
        logic [10:0] a1, a2, a3;
        a1 = dm_addr + 11'd1;
        a2 = dm_addr + 11'd2;
        a3 = dm_addr + 11'd3;
        if (dm_cs && dm_r) dm_rdata = {mem[dm_addr], mem[a1], mem[a2], mem[a3]};
        else               dm_rdata = 32'hDEADBEEF;
    end

    always @(negedge clk) begin
        logic [10:0] a1, a2, a3;
        a1 = dm_addr + 11'd1;
        a2 = dm_addr + 11'd2;
        a3 = dm_addr + 11'd3;
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'((i * 37) ^ (i >> 3));
            mem_init <= 1'b1;
        end else if (dm_cs && dm_w) begin
            case (dm_bits)
                2'd0: mem[dm_addr] <= dm_wdata[7:0];
                2'd1: begin
                    mem[dm_addr] <= dm_wdata[15:8];
                    mem[a1]      <= dm_wdata[7:0];
                end
                default: begin
                    mem[dm_addr] <= dm_wdata[31:24];
                    mem[a1]      <= dm_wdata[23:16];
                    mem[a2]      <= dm_wdata[15:8];
                    mem[a3]      <= dm_wdata[7:0];
                end
            endcase
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [7:0]  ref_mem [2048];
    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    int total = 0;
    int bad = 0;
    int cs_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Response {err, rdata} of one access, applied to the byte array.
    task automatic model(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [10:0] a, input logic [31:0] wd,
                         output logic [32:0] resp);
        int ai;
        logic [31:0] v;
        ai = int'(a);
        if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) begin
            resp = {1'b1, 32'h0};
            return;
        end
        if (w) begin
            case (sz)
                2'd0: ref_mem[ai] = wd[7:0];
                2'd1: begin
                    ref_mem[ai] = wd[15:8];
                    ref_mem[(ai + 1) % 2048] = wd[7:0];
                end
                default: for (int k = 0; k < 4; k++) ref_mem[(ai + k) % 2048] = wd[31 - 8*k -: 8];
            endcase
            resp = '0;
            return;
        end
        case (sz)
            2'd0: begin
                v = 32'(ref_mem[ai]);
                if (sx && v >= 32'd128) v = v + 32'hFFFFFF00;
            end
            2'd1: begin
                v = 32'(ref_mem[ai]) * 32'd256 + 32'(ref_mem[(ai + 1) % 2048]);
                if (sx && v >= 32'd32768) v = v + 32'hFFFF0000;
            end
            default: begin
                v = 32'h0;
                for (int k = 0; k < 4; k++) v = v * 32'd256 + 32'(ref_mem[(ai + k) % 2048]);
            end
        endcase
        resp = {1'b0, v};
    endtask

    task automatic monitor();
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (dm_cs) cs_cnt++;
            if (p0_ack && p1_ack) begin
                total++;
                bad++;
                $display("FAIL ack_overlap: got both acks want at most one");
            end
            if (p0_ack) begin
                if (q0.size() == 0) chk("p0_unexpected_ack", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("p0_resp", {p0_err, p0_rdata}, e);
                end
            end
            if (p1_ack) begin
                if (q1.size() == 0) chk("p1_unexpected_ack", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("p1_resp", {p1_err, p1_rdata}, e);
                end
            end
        end
    endtask

    // Issue one request on port p and hold it until its ack (bounded wait).
    task automatic issue(input int p, input logic w, input logic [1:0] sz, input logic sx,
                         input logic [10:0] a, input logic [31:0] wd,
                         output logic [31:0] got, output int lat);
        logic [32:0] resp;
        logic ack;
        model(w, sz, sx, a, wd, resp);
        if (p == 0) q0.push_back(resp);
        else        q1.push_back(resp);
        we_i[p] = w; size_i[p] = sz; sext_i[p] = sx; addr_i[p] = a; wdata_i[p] = wd;
        req_i[p] = 1'b1;
        lat = 0;
        got = 32'h0;
        while (1) begin
            @(negedge clk);
            lat++;
            ack = (p == 0) ? p0_ack : p1_ack;
            if (ack) begin
                got = (p == 0) ? p0_rdata : p1_rdata;
                break;
            end
            if (lat > 20) begin
                chk("ack_timeout", 0, 1);
                break;
            end
        end
        req_i[p] = 1'b0;
    endtask

    // Directed access from a known-idle point: checks data and 3-negedge latency.
    task automatic dir(input string nm, input int p, input logic w, input logic [1:0] sz,
                       input logic sx, input logic [10:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
        logic [31:0] got;
        int lat;
        @(posedge clk); #1;
        issue(p, w, sz, sx, a, wd, got, lat);
        chk({nm, "_rd"}, got, exp_rd);
        chk({nm, "_lat"}, lat, 3);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_ctl"}, {p0_ack, p1_ack, p0_err, p1_err, dm_cs, dm_r, dm_w, busy, dm_bits}, 0);
        chk({nm, "_rdata"}, {p0_rdata, p1_rdata}, 0);
        chk({nm, "_dm"}, {dm_addr, dm_wdata}, 0);
    endtask

    task automatic rand_port(input int p, input int n);
        logic [1:0]  sz;
        logic [10:0] a;
        logic [31:0] got;
        int r, lat;
        for (int i = 0; i < n; i++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = 11'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1)      a[0]   = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
            end
            a[10] = (p == 1);   // ports work in disjoint halves of memory
            issue(p, 1'($urandom), sz, 1'($urandom), a, $urandom, got, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int lat, cs0;
        logic [8:0] m0, m1;
        logic [32:0] e;

        for (int p = 0; p < 2; p++) begin
            req_i[p] = 0; we_i[p] = 0; sext_i[p] = 0; size_i[p] = 0; addr_i[p] = 0; wdata_i[p] = 0;
        end
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'((i * 37) ^ (i >> 3));
        fork monitor(); join_none

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Port 1 alone straight after reset
        issue(1, 1'b1, 2'd2, 1'b0, 11'h404, 32'hCAFEF00D, got, lat);
        chk("p1_first_lat", lat, 3);

        // Word store then byte/half/word loads
        cs0 = cs_cnt;
        dir("sw_010", 0, 1'b1, 2'd2, 1'b0, 11'h010, 32'h11223344, 32'h0);
        chk("sw_cs_cycles", cs_cnt - cs0, 1);
        dir("lbu_011", 0, 1'b0, 2'd0, 1'b0, 11'h011, 32'h0, 32'h00000022);
        dir("lhu_012", 0, 1'b0, 2'd1, 1'b0, 11'h012, 32'h0, 32'h00003344);
        dir("lw_010",  0, 1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 32'h11223344);
        dir("p1_lw",   1, 1'b0, 2'd2, 1'b0, 11'h404, 32'h0, 32'hCAFEF00D);

        // Sign extension
        dir("sb_020",  0, 1'b1, 2'd0, 1'b0, 11'h020, 32'h00000080, 32'h0);
        dir("lb_020",  0, 1'b0, 2'd0, 1'b1, 11'h020, 32'h0, 32'hFFFFFF80);
        dir("lbu_020", 0, 1'b0, 2'd0, 1'b0, 11'h020, 32'h0, 32'h00000080);

        // Misaligned halfword store: err, no memory activity
        cs0 = cs_cnt;
        dir("sh_003", 0, 1'b1, 2'd1, 1'b0, 11'h003, 32'h0000BEEF, 32'h0);
        chk("sh_003_no_cs", cs_cnt - cs0, 0);
        model(1'b0, 2'd2, 1'b0, 11'h000, 32'h0, e);
        q0.push_back(e);
        @(posedge clk); #1;
        issue(0, 1'b0, 2'd2, 1'b0, 11'h000, 32'h0, got, lat);
        void'(q0.pop_back());  // the model-driven issue pushed its own copy
        chk("lw_000_unchanged", got, e[31:0]);

        // Top of memory
        dir("sh_7fe",  0, 1'b1, 2'd1, 1'b0, 11'h7FE, 32'h0000ABCD, 32'h0);
        dir("lhu_7fe", 0, 1'b0, 2'd1, 1'b0, 11'h7FE, 32'h0, 32'h0000ABCD);

        // Reset sampled at the end of ACCESS of a load: no ack, outputs cleared
        @(posedge clk); #1;
        we_i[0] = 1'b0; size_i[0] = 2'd2; sext_i[0] = 1'b0; addr_i[0] = 11'h010;
        req_i[0] = 1'b1;
        @(posedge clk); #1;
        chk("mid_access_busy", {busy, dm_cs, dm_r}, 3'b111);
        rst = 1'b1;
        req_i[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("mid_reset");
        dir("lw_after_rst", 0, 1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 32'h11223344);

        // Arbitration: both ports hold req from reset, PRIO_INIT = 0
        @(posedge clk); #1;
        rst = 1'b1;
        we_i[0] = 1'b0; size_i[0] = 2'd2; sext_i[0] = 1'b0; addr_i[0] = 11'h010;
        we_i[1] = 1'b0; size_i[1] = 2'd2; sext_i[1] = 1'b0; addr_i[1] = 11'h404;
        req_i[0] = 1'b1; req_i[1] = 1'b1;
        model(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, e); q0.push_back(e); q0.push_back(e);
        model(1'b0, 2'd2, 1'b0, 11'h404, 32'h0, e); q1.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m0 = '0; m1 = '0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(negedge clk);
            m0[cyc] = p0_ack;
            m1[cyc] = p1_ack;
            if (cyc == 8) begin
                req_i[0] = 1'b0;
                req_i[1] = 1'b0;
            end
        end
        chk("arb_p0_ack_cycles", m0, 9'b100000100);
        chk("arb_p1_ack_cycles", m1, 9'b000100000);

        // Randomized traffic on both ports at once
        @(posedge clk); #1;
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        repeat (5) @(posedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
